fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch stage that generates the PC and issues instruction-memory reads.
- Drives f_instr / f_pc / f_valid into the fetch-to-decode pipeline register.
- Honors decode backpressure (stall) and branch/jump redirects from later stages.
- Contains a one-entry skid buffer, so a memory response arriving during a stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- MAX_WAIT, 16: cycles without imem_ack before fetch_err is set. Used only with FETCH_TIMEOUT_EN.

Ports:
- clock  in  1  : clock. All state changes on the rising edge.
- reset  in  1  : asynchronous, active-low reset (asserted when 0).
- stall  in  1  : decode cannot accept. Meaningful only while f_valid=1.
- redirect  in  1  : flush and restart fetch at redirect_pc.
- redirect_pc  in  32  : redirect target.
- imem_req  out  1  : read request to instruction memory.
- imem_addr  out  32  : read address. Stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  : read complete. imem_rdata is valid in the same cycle.
- imem_rdata  in  32  : instruction word.
- f_instr  out  32  : instruction to decode.
- f_pc  out  32  : PC of f_instr.
- f_valid  out  1  : f_instr / f_pc hold a real instruction.
- fetch_err  out  1  : sticky timeout flag. Present only with FETCH_TIMEOUT_EN.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=IDLE.
  - f_instr=0, f_pc=0, f_valid=0, imem_req=0, imem_addr=RESET_PC.
  - Skid buffer empty; fetch_err=0.
- Transfer rule: f_valid=1 and stall=0 at a clock edge means decode consumes the instruction.
  - slot_free = !f_valid | !stall.
- imem protocol:
  - imem_req=1 only in states REQ and DROP.
  - imem_addr=pc, held constant until imem_ack is sampled high.
  - Zero-wait ack (ack in the first request cycle) is legal.
  - The fetch unit never withdraws a request.
- States:
  - IDLE: imem_req=0. Next state REQ. Lasts exactly one cycle after reset release.
  - REQ, on ack with slot_free: f_instr<=imem_rdata, f_pc<=pc, f_valid<=1, pc<=pc+4. Stay in REQ. Zero-wait memory gives 1 instruction per cycle.
  - REQ, on ack with !slot_free: buffer<={imem_rdata, pc}, pc<=pc+4, go to HOLD.
  - REQ, no ack: hold. If slot_free, f_valid<=0 (consumed output becomes a bubble).
  - HOLD: imem_req=0. When stall=0, output<=buffer (f_valid=1), buffer empties, go to REQ.
  - DROP: imem_req=1 at the stale address. On ack, discard imem_rdata and go to REQ. The request at the new pc is issued the following cycle.
- Redirect (highest priority, overrides stall):
  - Always: pc<=redirect_pc, f_valid<=0, buffer cleared. f_instr/f_pc keep their old values but are invalid.
  - In REQ without ack: go to DROP. imem_addr stays at the old address until ack.
  - In REQ with ack in the same cycle: data discarded, go to REQ.
  - In HOLD or IDLE: go to REQ.
  - In DROP: pc takes the newest redirect_pc, stay in DROP.
- Arithmetic: pc+4 is 32-bit modulo. 0xFFFF_FFFC wraps to 0x0000_0000. No alignment check.
- Ordering: the fetch order is the PC sequence. No instruction is ever duplicated or skipped except by redirect.
- stall while f_valid=0: ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter runs while imem_req=1 and imem_ack=0. It clears on ack and on reset.
  - When the count reaches MAX_WAIT, fetch_err<=1.
  - fetch_err is sticky until reset. Fetch behaviour is otherwise unchanged; the request stays pending.
- Not defined: no counter and no fetch_err port.

Test Plan:
- Reset: RESET_PC=0x100, zero-wait ack, stall=0.
  - After reset release, IDLE lasts 1 cycle.
  - imem_addr then goes 0x100, 0x104, 0x108 on consecutive cycles.
  - f_valid=1 from the 2nd edge after release, with f_pc 0x100, 0x104, 0x108 and matching f_instr.
- Ack latency 3 cycles: each imem_addr is held for exactly 3 cycles. f_valid pulses 1 cycle per instruction, and f_pc increments by 4.
- Stall for 4 cycles while a response arrives:
  - f_instr/f_pc stay frozen and imem_req=0 (HOLD).
  - After stall drops, the buffered instruction appears next cycle with f_pc = previous f_pc + 4.
  - No instruction is lost or duplicated.
- Redirect to 0x2000 while a request to 0x10C is pending (ack 2 cycles later):
  - f_valid=0 on the next edge.
  - imem_addr stays at 0x10C until ack, and that data is dropped.
  - The next request is to 0x2000.
- Redirect to 0xFFFF_FFFC, zero-wait ack: f_pc sequence is 0xFFFF_FFFC, then 0x0000_0000.
- FETCH_TIMEOUT_EN, MAX_WAIT=8, ack withheld:
  - fetch_err rises after 8 waiting cycles.
  - It stays 1 after a later ack.
  - reset=0 clears it.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, imem request sequencing and a one-entry skid buffer.
// Optional macro FETCH_TIMEOUT_EN adds a sticky fetch_err flag for requests that never complete.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
`ifdef FETCH_TIMEOUT_EN
    output logic        f_valid,
    output logic        fetch_err
`else
    output logic        f_valid
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;
    localparam logic [1:0] StDrop = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        valid_q, valid_d;
    logic        slot_free;

    assign slot_free = !valid_q || !stall;

    // In DROP the stale address must stay on the bus while pc already tracks the new target.
    assign imem_req  = (state_q == StReq) || (state_q == StDrop);
    assign imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;
    assign f_instr   = instr_q;
    assign f_pc      = out_pc_q;
    assign f_valid   = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        out_pc_d    = out_pc_q;
        valid_d     = valid_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            unique case (state_q)
                StReq: begin
                    if (!imem_ack) begin
                        state_d     = StDrop;
                        drop_addr_d = pc_q;
                    end
                end
                StDrop:  state_d = imem_ack ? StReq : StDrop;
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (slot_free) begin
                            instr_d  = imem_rdata;
                            out_pc_d = pc_q;
                            valid_d  = 1'b1;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_q;
                            state_d     = StHold;
                        end
                    end else if (slot_free) begin
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        instr_d  = buf_instr_q;
                        out_pc_d = buf_pc_q;
                        valid_d  = 1'b1;
                        state_d  = StReq;
                    end
                end
                StDrop: begin
                    if (imem_ack) state_d = StReq;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            instr_q     <= 32'd0;
            out_pc_q    <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            out_pc_q    <= out_pc_d;
            valid_q     <= valid_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic [WaitW-1:0] wait_cnt_q;
    logic             err_q;

    // Counter saturates at MAX_WAIT; the request itself is left pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (imem_req && !imem_ack) begin
            if (wait_cnt_q != WaitW'(MAX_WAIT)) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q >= WaitW'(MAX_WAIT - 1)) err_q <= 1'b1;
        end else if (imem_ack) begin
            wait_cnt_q <= '0;
        end
    end

    assign fetch_err = err_q;
`else
    // Without the timeout option there is no wait counter and no fetch_err port.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable imem responder plus a PC-order scoreboard.
// Define FETCH_TIMEOUT_EN for both files to also exercise the fetch_err timeout.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_valid;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit hold_ack = 1'b0;
    int wcnt = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .RESET_PC(32'h0000_0100),
        .MAX_WAIT(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .f_instr    (f_instr),
        .f_pc       (f_pc),
`ifdef FETCH_TIMEOUT_EN
        .fetch_err  (fetch_err),
`endif
        .f_valid    (f_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack in the lat-th cycle of each request, data keyed on the address.
    always @(negedge clock) begin
        imem_ack   = imem_req && !hold_ack && (wcnt + 1 >= lat);
        imem_rdata = imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge clock) begin
        if (!reset) wcnt = 0;
        else if (imem_req) wcnt = imem_ack ? 0 : wcnt + 1;
    end

    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 600; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (f_valid !== 1'b0 || imem_req !== 1'b0 || f_pc !== 32'd0 || f_instr !== 32'd0 ||
            imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_values: valid=%b req=%b pc=%h instr=%h addr=%h, want 0 0 0 0 100",
                     f_valid, imem_req, f_pc, f_instr, imem_addr);
        end
        sb_restart(32'h100);
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: imem_req=%b, want 0", imem_req);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i < 3) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h100 + 32'(4 * i) ||
                    f_valid !== (i > 0)) begin
                    errors++;
                    $display("FAIL reset_seq[%0d]: req=%b addr=%h valid=%b, want 1 %h %b", i,
                             imem_req, imem_addr, f_valid, 32'h100 + 32'(4 * i), i > 0);
                end
            end
            if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL reset_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
    endtask

    task automatic test_latency3();
        logic [31:0] e, prev_addr;
        int run = 0;
        bit started = 1'b0;
        bit prev_valid;
        lat = 3;
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            if (i == 6) begin
                prev_addr  = imem_addr;
                prev_valid = f_valid;
            end else if (i > 6) begin
                if (imem_req) begin
                    if (imem_addr === prev_addr) run++;
                    else begin
                        if (started) begin
                            checks++;
                            if (run != 3) begin
                                errors++;
                                $display("FAIL addr_hold: addr %h held %0d cycles, want 3",
                                         prev_addr, run);
                            end
                        end
                        started   = 1'b1;
                        run       = 1;
                        prev_addr = imem_addr;
                    end
                end
                if (f_valid) begin
                    checks++;
                    if (prev_valid) begin
                        errors++;
                        $display("FAIL valid_pulse: f_valid high 2 cycles at pc=%h, want 1",
                                 f_pc);
                    end
                end
                prev_valid = f_valid;
            end
            if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL latency_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] e, pc0, instr0;
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clock);
            if (f_valid) begin
                stall = 1'b1;
                found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stall_wait: f_valid=%b after 12 cycles, want 1", f_valid);
        end
        pc0    = f_pc;
        instr0 = f_instr;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (f_valid !== 1'b1 || f_pc !== pc0 || f_instr !== instr0) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h", k,
                         f_valid, f_pc, f_instr, pc0, instr0);
            end
            if (k == 3) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_req: imem_req=%b in HOLD, want 0", imem_req);
                end
            end
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            stall = 1'b0;
            if (i == 1) begin
                checks++;
                if (f_valid !== 1'b1 || f_pc !== pc0 + 32'd4) begin
                    errors++;
                    $display("FAIL skid_out: valid=%b pc=%h, want 1 %h", f_valid, f_pc,
                             pc0 + 32'd4);
                end
            end
            if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL stall_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        bit found = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        lat   = 3;
        sb_restart(32'h100);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (imem_req && imem_addr === 32'h10C) begin
                found       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 32'h2000;
                sb_restart(32'h2000);
            end else if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL pre_redirect_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_setup: no request to 0x10C seen, last addr=%h", imem_addr);
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            redirect = 1'b0;
            if (i < 3) begin
                checks++;
                if (f_valid !== 1'b0 || imem_req !== 1'b1 ||
                    imem_addr !== ((i < 2) ? 32'h10C : 32'h2000)) begin
                    errors++;
                    $display("FAIL redirect_drop[%0d]: valid=%b req=%b addr=%h, want 0 1 %h", i,
                             f_valid, imem_req, imem_addr, (i < 2) ? 32'h10C : 32'h2000);
                end
            end
            if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL redirect_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        logic [31:0] got[2];
        int n = 0;
        lat = 1;
        repeat (4) begin
            @(negedge clock);
            if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL wrap_pre_order: pc=%h, want %h", f_pc, e);
                end
            end
        end
        @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        sb_restart(32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            redirect = 1'b0;
            if (f_valid && !stall && !redirect) begin
                if (n < 2) got[n] = f_pc;
                n++;
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL wrap_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
        checks++;
        if (n < 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_seq: got %0d instrs first=%h second=%h, want fffffffc 00000000",
                     n, got[0], got[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, tgt;
        int taken = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 39) == 0);
            if (c % 25 == 0) lat = $urandom_range(1, 3);
            if (c == 299) begin
                stall    = 1'b0;
                redirect = 1'b0;
            end
            if (redirect) begin
                tgt         = $urandom & 32'hFFFF_FFFC;
                redirect_pc = tgt;
                sb_restart(tgt);
            end else if (f_valid && !stall) begin
                taken++;
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL random_order: pc=%h instr=%h, want pc=%h instr=%h",
                             f_pc, f_instr, e, instr_of(e));
                end
            end
        end
        checks++;
        if (taken < 30) begin
            errors++;
            $display("FAIL random_progress: %0d instructions delivered, want at least 30", taken);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] e;
        @(negedge clock);
        reset    = 1'b0;
        hold_ack = 1'b1;
        stall    = 1'b0;
        lat      = 1;
        sb_restart(32'h100);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            checks++;
            if (fetch_err !== (k == 9) || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL timeout_rise[%0d]: fetch_err=%b req=%b, want %b 1", k, fetch_err,
                         imem_req, k == 9);
            end
        end
        hold_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (f_valid && !stall && !redirect) begin
                e = exp_q.pop_front();
                checks++;
                if (f_pc !== e || f_instr !== instr_of(e)) begin
                    errors++;
                    $display("FAIL timeout_order: pc=%h, want %h", f_pc, e);
                end
            end
        end
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: fetch_err=%b after ack, want 1", fetch_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: fetch_err=%b in reset, want 0", fetch_err);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency3();
        test_stall_hold();
        test_redirect();
        test_wrap();
        test_back_to_back();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
